// File: rtl/lr35902_oam_dma.sv
// OAM DMA engine: a write to FF46 copies NUM_BYTES bytes from {src,8'h00} into OAM.
// It is the sole initiator on the external bus; VRAM sources stay on the internal bus.
module lr35902_oam_dma #(
  parameter int NUM_BYTES       = 160,
  parameter int CYCLES_PER_BYTE = 4,
  parameter int START_DELAY     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  reg_din,
  output logic [7:0]  reg_dout,
  input  logic        reg_read,
  input  logic        reg_write,
  output logic        dma_active,
  output logic        drv_ext,
  output logic [15:0] adr_rd,
  output logic        rd,
  input  logic [7:0]  data_in,
  output logic [7:0]  adr_wr,
  output logic        wr,
  output logic [7:0]  data_out
);

  localparam int PW = $clog2(CYCLES_PER_BYTE);
  localparam int CW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [PW-1:0] PH_LAST  = PW'(CYCLES_PER_BYTE - 1);
  localparam logic [PW-1:0] PH_LATCH = PW'(CYCLES_PER_BYTE - 2);
  localparam logic [7:0]    IDX_LAST = 8'(NUM_BYTES - 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(START_DELAY - 1);

  typedef enum logic [1:0] {IDLE, START, XFER} state_t;

  state_t        state, state_n;
  logic [7:0]    src, src_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    idx, idx_n;
  logic [PW-1:0] phase, phase_n;
  logic          restart, restart_n;
  logic [7:0]    eff_n;
  logic          xfer_n;
  logic          wr_n;

  // Echo RAM E000-FDFF aliases C000-DDFF.
  function automatic logic [7:0] echo_fold(input logic [7:0] s);
    return (s >= 8'hE0) ? s - 8'h20 : s;
  endfunction

  // reg_read is a pure readback strobe with no side effect on the engine.
  assign reg_dout = src;

  always_comb begin
    state_n   = state;
    src_n     = src;
    cnt_n     = cnt;
    idx_n     = idx;
    phase_n   = phase;
    restart_n = restart;
    case (state)
      IDLE: begin
        if (reg_write) begin
          src_n     = reg_din;
          cnt_n     = CNT_INIT;
          state_n   = START;
          restart_n = 1'b0;
        end
      end
      START: begin
        if (reg_write) begin
          src_n = reg_din;
          cnt_n = CNT_INIT;
        end else if (cnt == '0) begin
          state_n = XFER;
          idx_n   = '0;
          phase_n = '0;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      XFER: begin
        if (reg_write) begin
          src_n     = reg_din;
          cnt_n     = CNT_INIT;
          state_n   = START;
          restart_n = 1'b1;
        end else if (phase == PH_LAST) begin
          phase_n = '0;
          if (idx == IDX_LAST) begin
            idx_n   = '0;
            state_n = IDLE;
          end else begin
            idx_n = idx + 8'd1;
          end
        end else begin
          phase_n = phase + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  assign eff_n  = echo_fold(src_n);
  assign xfer_n = (state_n == XFER);
  assign wr_n   = xfer_n && (phase_n == PH_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      src        <= 8'hFF;
      cnt        <= '0;
      idx        <= '0;
      phase      <= '0;
      restart    <= 1'b0;
      dma_active <= 1'b0;
      drv_ext    <= 1'b0;
      rd         <= 1'b0;
      wr         <= 1'b0;
      adr_rd     <= '0;
      adr_wr     <= '0;
      data_out   <= '0;
    end else begin
      state      <= state_n;
      src        <= src_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      phase      <= phase_n;
      restart    <= restart_n;
      dma_active <= xfer_n || ((state_n == START) && restart_n);
      rd         <= xfer_n;
      drv_ext    <= xfer_n && (eff_n[7:5] != 3'b100);
      wr         <= wr_n;
      if (xfer_n)
        adr_rd <= {eff_n, idx_n};
      if (wr_n)
        adr_wr <= idx_n;
      if ((state == XFER) && (phase == PH_LATCH) && !reg_write)
        data_out <= data_in;
    end
  end

endmodule

// File: tb/tb_lr35902_oam_dma.sv
// Directed bench for lr35902_oam_dma: full transfers, VRAM/echo sources, restart, reset, back-to-back.
module tb_lr35902_oam_dma;

  localparam int CPB = 4;
  localparam int NB  = 160;
  localparam int SD  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  reg_din;
  logic [7:0]  reg_dout;
  logic        reg_read;
  logic        reg_write;
  logic        dma_active;
  logic        drv_ext;
  logic [15:0] adr_rd;
  logic        rd;
  logic [7:0]  data_in = 8'h00;
  logic [7:0]  adr_wr;
  logic        wr;
  logic [7:0]  data_out;

  int vectors = 0;
  int errors  = 0;

  lr35902_oam_dma #(
    .NUM_BYTES(NB),
    .CYCLES_PER_BYTE(CPB),
    .START_DELAY(SD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .reg_din(reg_din),
    .reg_dout(reg_dout),
    .reg_read(reg_read),
    .reg_write(reg_write),
    .dma_active(dma_active),
    .drv_ext(drv_ext),
    .adr_rd(adr_rd),
    .rd(rd),
    .data_in(data_in),
    .adr_wr(adr_wr),
    .wr(wr),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  // Source memory contents as a fixed function of address, with one cycle read latency.
  function automatic logic [7:0] mem_f(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
  endfunction

  always @(posedge clk) data_in <= mem_f(adr_rd);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_active"}, dma_active, 16'd0);
    chk({tag, "_rd"}, rd, 16'd0);
    chk({tag, "_drv_ext"}, drv_ext, 16'd0);
    chk({tag, "_wr"}, wr, 16'd0);
  endtask

  // Issue an FF46 write in the current cycle and advance one cycle.
  task automatic start_write(input logic [7:0] d);
    reg_din   = d;
    reg_write = 1'b1;
    tick;
    reg_write = 1'b0;
  endtask

  // START_DELAY cycles of START; leaves the bench positioned on the first XFER cycle.
  task automatic check_start(input logic active_exp);
    for (int i = 0; i < SD; i++) begin
      chk("start_active", dma_active, {15'd0, active_exp});
      chk("start_rd", rd, 16'd0);
      chk("start_drv_ext", drv_ext, 16'd0);
      chk("start_wr", wr, 16'd0);
      tick;
    end
  endtask

  // Checks transfer cycles k=0..n-1; no tick after the last one.
  task automatic xfer_cycles(input logic [7:0] eff, input logic ext, input int n);
    for (int k = 0; k < n; k++) begin
      logic [7:0] b;
      int ph;
      b  = 8'(k / CPB);
      ph = k % CPB;
      chk("xfer_active", dma_active, 16'd1);
      chk("xfer_rd", rd, 16'd1);
      chk("xfer_drv_ext", drv_ext, {15'd0, ext});
      chk("xfer_adr_rd", adr_rd, {eff, b});
      chk("xfer_wr", wr, {15'd0, ph == CPB - 1});
      if (ph == CPB - 1) begin
        chk("xfer_adr_wr", adr_wr, {8'd0, b});
        chk("xfer_data_out", data_out, {8'd0, mem_f({eff, b})});
      end
      if (k < n - 1) tick;
    end
  endtask

  initial begin
    reset     = 1'b1;
    reg_din   = 8'h00;
    reg_read  = 1'b0;
    reg_write = 1'b0;
    tick;
    tick;
    chk("rst_reg_dout", reg_dout, 16'h00FF);
    chk("rst_adr_rd", adr_rd, 16'h0000);
    chk("rst_adr_wr", adr_wr, 16'h0000);
    chk("rst_data_out", data_out, 16'h0000);
    check_idle("rst");
    reset = 1'b0;
    tick;
    check_idle("post_rst");

    // Plain WRAM transfer from C100.
    start_write(8'hC1);
    chk("c1_reg_dout", reg_dout, 16'h00C1);
    check_start(1'b0);
    xfer_cycles(8'hC1, 1'b1, NB * CPB);
    tick;
    check_idle("c1_done");

    // VRAM source: internal bus, no external drive.
    start_write(8'h80);
    check_start(1'b0);
    xfer_cycles(8'h80, 1'b0, NB * CPB);
    tick;
    check_idle("v80_done");

    // Echo RAM source folds to C200; reg_read held high has no effect.
    reg_read = 1'b1;
    start_write(8'hE2);
    chk("e2_reg_dout", reg_dout, 16'h00E2);
    check_start(1'b0);
    xfer_cycles(8'hC2, 1'b1, NB * CPB);
    tick;
    check_idle("e2_done");
    reg_read = 1'b0;

    // Restart at byte 50 phase 1: byte 50 never written, dma_active held.
    start_write(8'hC0);
    check_start(1'b0);
    xfer_cycles(8'hC0, 1'b1, 50 * CPB + 2);
    start_write(8'hD0);
    chk("rs_reg_dout", reg_dout, 16'h00D0);
    check_start(1'b1);
    xfer_cycles(8'hD0, 1'b1, NB * CPB);
    tick;
    check_idle("rs_done");

    // Reset at byte 20 phase 0.
    start_write(8'hC4);
    check_start(1'b0);
    xfer_cycles(8'hC4, 1'b1, 20 * CPB + 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check_idle("mid_rst");
    chk("mid_rst_reg_dout", reg_dout, 16'h00FF);
    chk("mid_rst_adr_rd", adr_rd, 16'h0000);
    chk("mid_rst_data_out", data_out, 16'h0000);
    tick;
    check_idle("mid_rst_hold");

    // Clean restart after reset, then a write landing on the final byte's wr.
    start_write(8'hC6);
    check_start(1'b0);
    xfer_cycles(8'hC6, 1'b1, NB * CPB);
    chk("b2b_last_wr", wr, 16'd1);
    chk("b2b_last_adr_wr", adr_wr, 16'd159);
    start_write(8'hC5);
    check_start(1'b1);
    xfer_cycles(8'hC5, 1'b1, NB * CPB);
    tick;
    check_idle("b2b_done");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
